// File: rtl/dmem_responder.sv
// Purpose : MEM-stage data-memory responder. Handles one word load/store at a time with byte enables.
// Latency : a request accepted at edge N is acked in cycle N+1+WAIT_CYCLES; issue interval is WAIT_CYCLES+2.
// Backpres: ready_o is low outside IDLE; stallreq_o freezes the pipe until the ack cycle.
// Ports   : clk_i/rst_i (async active-high reset); req_i/we_i/addr_i/wdata_i/be_i request, held until ack_o;
//           ready_o idle flag; ack_o one-cycle completion; rdata_o registered read word, held between acks;
//           err_o rejected-request flag alongside ack_o; stallreq_o pipeline freeze request.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    ready_o,
  output logic                    ack_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    stallreq_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state;
  logic [3:0]            cnt;

  // Request copy captured at accept; WAIT uses only these.
  logic                  lat_we;
  logic                  lat_err;
  logic [IDX_W-1:0]      lat_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_W-1:0]       lat_be;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Error check on the incoming request. The full word address is compared so that
  // nonzero upper bits cannot alias onto a valid index.
  logic [ADDR_WIDTH-1:0] in_word;
  logic                  in_err;
  logic                  unused_addr_lsb;

  assign in_word         = {2'b00, addr_i[ADDR_WIDTH-1:2]};
  assign in_err          = (in_word >= ADDR_WIDTH'(DEPTH_WORDS)) || (we_i && (be_i == '0));
  assign unused_addr_lsb = ^addr_i[1:0];

  // Commit-side view of the request. With zero wait states the commit edge is the
  // accept edge itself, so the live inputs are used; otherwise the latched copy.
  logic                  accept;
  logic                  commit;
  logic                  c_we;
  logic                  c_err;
  logic [IDX_W-1:0]      c_idx;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [BE_W-1:0]       c_be;

  assign accept = (state == S_IDLE) && req_i;
  assign commit = (WAIT_CYCLES == 0) ? accept : ((state == S_WAIT) && (cnt == '0));

  always_comb begin
    c_we    = lat_we;
    c_err   = lat_err;
    c_idx   = lat_idx;
    c_wdata = lat_wdata;
    c_be    = lat_be;
    if (state == S_IDLE) begin
      c_we    = we_i;
      c_err   = in_err;
      c_idx   = addr_i[IDX_W+1:2];
      c_wdata = wdata_i;
      c_be    = be_i;
    end
  end

  assign ready_o    = (state == S_IDLE);
  assign stallreq_o = accept || (state == S_WAIT);

  // Array write port. No reset on the array; the rst_i gate keeps a request that is
  // reset on its commit edge from writing.
  always_ff @(posedge clk_i) begin
    if (commit && !rst_i && c_we && !c_err) begin
      for (int k = 0; k < BE_W; k++) begin
        if (c_be[k]) mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      // ack/err are high exactly in the RESP cycle.
      ack_o <= commit;
      err_o <= commit && c_err;

      // Registered read; stores leave rdata_o untouched unless rejected.
      if (commit) begin
        if (c_err) rdata_o <= '0;
        else if (!c_we) rdata_o <= mem[c_idx];
      end

      case (state)
        S_IDLE: begin
          if (req_i) begin
            lat_we    <= we_i;
            lat_err   <= in_err;
            lat_idx   <= addr_i[IDX_W+1:2];
            lat_wdata <= wdata_i;
            lat_be    <= be_i;
            if (WAIT_CYCLES > 0) begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else cnt <= cnt - 4'd1;
        end
        S_RESP: begin
          // A req_i still high here belongs to the request just finished.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // WAIT_CYCLES = 2 instance
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, ack, err, stall;
  logic [31:0] rdata;

  // WAIT_CYCLES = 0 instance
  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        ready0, ack0, err0, stall0;
  logic [31:0] rdata0;

  int vectors     = 0;
  int miscompares = 0;

  dmem_responder #(.WAIT_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .ready_o(ready), .ack_o(ack), .rdata_o(rdata), .err_o(err), .stallreq_o(stall)
  );

  dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .wdata_i(wdata0), .be_i(be0),
    .ready_o(ready0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0), .stallreq_o(stall0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the main instance, waits (bounded) for ack, returns the
  // ack-cycle outputs and the accept-to-ack cycle count, then drops req and idles a cycle.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic er, output int lat);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ack !== 1'b1 && lat < 20);
    rd  = rdata;
    er  = err;
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    #12;
    vectors++;
    if ({ready, ack, err, stall, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_main: got rdy/ack/err/stall/rdata=%b%b%b%b/%h want 1000/00000000",
               ready, ack, err, stall, rdata);
    end
    vectors++;
    if ({ready0, ack0, err0, stall0, rdata0} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_zw: got rdy/ack/err/stall/rdata=%b%b%b%b/%h want 1000/00000000",
               ready0, ack0, err0, stall0, rdata0);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word_store();
    logic [3:0] exp;
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; be = 4'hF;
    #1;
    for (int c = 0; c <= 4; c++) begin
      exp = {(c <= 2), (c == 3), 1'b0, (c == 0 || c == 4)};
      vectors++;
      if ({stall, ack, err, ready} !== exp) begin
        miscompares++;
        $display("FAIL word_store_c%0d: got stall/ack/err/rdy=%b want %b", c, {stall, ack, err, ready}, exp);
      end
      if (c == 3) req = 1'b0;
      if (c < 4) tick();
    end
  endtask

  task automatic test_byte_store_load();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er, lat);
    vectors++;
    if (lat !== 3 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_store: got lat=%0d err=%b want lat=3 err=0", lat, er);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0 || lat !== 3) begin
      miscompares++;
      $display("FAIL byte_load: got rdata=%h err=%b lat=%0d want DEADAAEF 0 3", rd, er, lat);
    end
    vectors++;
    if (rdata !== 32'hDEADAAEF || ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rdata_hold: got rdata=%h ack=%b want DEADAAEF 0", rdata, ack);
    end
    do_req(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
      miscompares++;
      $display("FAIL load_be0: got rdata=%h err=%b want DEADAAEF 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++;
      $display("FAIL store_20: got err=%b want 0", er);
    end
    do_req(1'b0, 32'h00001000, 32'h0, 4'hF, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 3) begin
      miscompares++;
      $display("FAIL oor_load: got rdata=%h err=%b lat=%0d want 00000000 1 3", rd, er, lat);
    end
    do_req(1'b0, 32'h80000010, 32'h0, 4'hF, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL upper_bits: got rdata=%h err=%b want 00000000 1", rd, er);
    end
    do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    vectors++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL store_be0: got err=%b rdata=%h want 1 00000000", er, rd);
    end
    do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    vectors++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL mem8_kept: got rdata=%h err=%b want 11223344 0", rd, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int acks;
    // rdata is 11223344 from the previous load, so a clear is observable.
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h12345678; be = 4'hF;
    tick();
    rst = 1'b1;
    req = 1'b0;
    #1;
    vectors++;
    if ({ready, ack, err, stall, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy/ack/err/stall/rdata=%b%b%b%b/%h want 1000/00000000",
               ready, ack, err, stall, rdata);
    end
    tick();
    tick();
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    vectors++;
    if (acks !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_ack: got %0d acks want 0", acks);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_nowrite: got rdata=%h err=%b want DEADAAEF 0", rd, er);
    end
  endtask

  task automatic test_wait_inputs();
    logic [31:0] rd; logic er; int lat;
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'hF;
    tick();
    we = 1'b0; addr = 32'h00001000; wdata = 32'h0; be = 4'h0;
    tick();
    tick();
    vectors++;
    if (ack !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_latch_ack: got ack=%b err=%b want 1 0", ack, err);
    end
    req = 1'b0;
    tick();
    do_req(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    vectors++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_latch_data: got rdata=%h err=%b want CAFEF00D 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0; be = 4'hF;
    #1;
    for (int c = 0; c <= 8; c++) begin
      exp = {(c == 3 || c == 7), (c == 0 || c == 4 || c == 8), (c != 3 && c != 7 && c != 8)};
      vectors++;
      if ({ack, ready, stall} !== exp) begin
        miscompares++;
        $display("FAIL b2b_c%0d: got ack/rdy/stall=%b want %b", c, {ack, ready, stall}, exp);
      end
      if (c == 3) begin
        vectors++;
        if (rdata !== 32'hDEADAAEF) begin
          miscompares++;
          $display("FAIL b2b_rd1: got %h want DEADAAEF", rdata);
        end
        addr = 32'h20;
      end
      if (c == 7) begin
        vectors++;
        if (rdata !== 32'h11223344) begin
          miscompares++;
          $display("FAIL b2b_rd2: got %h want 11223344", rdata);
        end
        req = 1'b0;
      end
      if (c < 8) tick();
    end
  endtask

  task automatic test_zero_wait();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hA5A55A5A; be0 = 4'hF;
    #1;
    vectors++;
    if ({stall0, ack0} !== 2'b10) begin
      miscompares++;
      $display("FAIL zw_store_c0: got stall/ack=%b want 10", {stall0, ack0});
    end
    tick();
    vectors++;
    if ({stall0, ack0, err0, ready0} !== 4'b0100) begin
      miscompares++;
      $display("FAIL zw_store_c1: got stall/ack/err/rdy=%b want 0100", {stall0, ack0, err0, ready0});
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({stall0, ack0, ready0} !== 3'b001) begin
      miscompares++;
      $display("FAIL zw_store_c2: got stall/ack/rdy=%b want 001", {stall0, ack0, ready0});
    end
    req0 = 1'b1; we0 = 1'b0;
    #1;
    vectors++;
    if ({stall0, ack0} !== 2'b10) begin
      miscompares++;
      $display("FAIL zw_load_c0: got stall/ack=%b want 10", {stall0, ack0});
    end
    tick();
    vectors++;
    if ({stall0, ack0} !== 2'b01 || rdata0 !== 32'hA5A55A5A) begin
      miscompares++;
      $display("FAIL zw_load_c1: got stall/ack=%b rdata=%h want 01 A5A55A5A", {stall0, ack0}, rdata0);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if (ack0 !== 1'b0 || rdata0 !== 32'hA5A55A5A) begin
      miscompares++;
      $display("FAIL zw_hold: got ack=%b rdata=%h want 0 A5A55A5A", ack0, rdata0);
    end
    req0 = 1'b1; addr0 = 32'h00001000;
    tick();
    vectors++;
    if ({ack0, err0} !== 2'b11 || rdata0 !== 32'h0) begin
      miscompares++;
      $display("FAIL zw_oor: got ack/err=%b rdata=%h want 11 00000000", {ack0, err0}, rdata0);
    end
    req0 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store_load();
    test_errors();
    test_reset_mid();
    test_wait_inputs();
    test_back_to_back();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
